lifo_pop_ctrl: RTL and testbench
================================

Name: lifo_pop_ctrl

Overview:
Read-side controller for the 8-bit, 16-deep LIFO. On a start command it pops a programmed number of entries, or drains the LIFO until it is empty. Each popped word is forwarded on a valid/ready output stream, and the block keeps a pop count and an XOR checksum. It sits between the LIFO (driving re, consuming dataout/empty) and any downstream consumer.

Parameters:
DATA_W, 8, width of LIFO data and output stream
CNT_W, 5, width of pop_count/popped; must hold LIFO depth (16)

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a pop sequence; ignored while busy=1
pop_count  input  CNT_W  entries to pop; 0 = drain until empty; latched on accepted start
lifo_re  output  1  read (pop) strobe to LIFO
lifo_dataout  input  DATA_W  LIFO read data
lifo_empty  input  1  LIFO empty flag
m_data  output  DATA_W  popped word to consumer
m_valid  output  1  m_data valid
m_ready  input  1  consumer accepts m_data
busy  output  1  high from the cycle after accepted start until DONE exits
done  output  1  one-cycle pulse at sequence end
underrun  output  1  sequence ended on empty before pop_count reached; held until next start
popped  output  CNT_W  entries popped in current/last sequence
checksum  output  DATA_W  XOR of all words popped in current/last sequence

Behaviour:
- Clock/reset: one clock clk; reset resetn is asynchronous and active-low.
- Reset (asynchronous, immediate): state IDLE. lifo_re, m_valid, busy, done and underrun = 0. m_data, popped and checksum = 0. Latched count = 0.
- LIFO timing contract: the LIFO updates dataout at the rising edge where re=1 and empty=0. Data is valid the cycle after the re cycle.
- System rule: the LIFO writer stays idle while busy=1. lifo_empty is therefore stable during a sequence.
- State machine (all outputs are Moore; lifo_re is high only in POP):
  - IDLE: on start=1, latch pop_count, clear popped/checksum/underrun, then go to CHECK.
  - CHECK:
    - If the latched count is nonzero and popped equals it, go to DONE.
    - Else if lifo_empty=1, go to DONE. If the latched count is nonzero, set underrun=1.
    - Else go to POP.
  - POP: lifo_re=1 for exactly one cycle, then go to CAP.
  - CAP: at the exit edge, m_data <= lifo_dataout, popped <= popped+1, checksum <= checksum ^ lifo_dataout. Go to OUT.
  - OUT: m_valid=1 with m_data stable. When m_valid and m_ready are both high at an edge, go to CHECK.
  - DONE: done=1 for one cycle, then go to IDLE.
- Latency: start is sampled at edge E0. lifo_re is high in cycle 2 after E0. m_valid is first high in cycle 4. With m_ready held high, sustained throughput is 1 word per 4 cycles.
- Ordering: words are emitted in LIFO order (last pushed first). The block never reorders or drops words.
- Backpressure: m_ready may stay low indefinitely. m_data and m_valid are held, and no further lifo_re is issued.
- lifo_re is never asserted when lifo_empty was 1 in the preceding CHECK. The block never pops more than pop_count entries.
- start while busy is ignored, with no effect on the latched count.
- popped saturates only by construction: at most depth pops per sequence, and drain mode stops on empty.
- popped, checksum and underrun hold their values after DONE until the next accepted start. m_data holds its last value.
- Reset mid-operation: all outputs clear immediately and any in-flight word is discarded. LIFO contents are not affected by this block's reset, because the LIFO has its own reset.

Test Plan:
1. Push 0x11, 0x22, 0x33. Start with pop_count=2 and m_ready=1. Expect m_data 0x33 then 0x22, popped=2, checksum=0x11, underrun=0, a done pulse, and exactly 2 lifo_re pulses.
2. Push 16 random bytes. Start with pop_count=0 (drain). Expect 16 words in reverse push order, popped=16, checksum equal to the XOR of all 16, underrun=0, and lifo_empty=1 at done.
3. Push 0xA5, 0x5A. Start with pop_count=4. Expect outputs 0x5A, 0xA5, popped=2, checksum=0xFF, underrun=1, a done pulse, and no lifo_re after the LIFO goes empty.
4. Backpressure: during an OUT beat, hold m_ready=0 for 5 cycles. Expect m_valid=1 and m_data stable throughout, no lifo_re, and the sequence resuming on m_ready=1.
5. Empty LIFO: start with pop_count=0. Expect done within 2 cycles after the start edge, popped=0, underrun=0, and lifo_re never asserted. Then pulse start while busy in a separate run and check it is ignored.
6. Assert resetn=0 while in OUT. Expect m_valid, busy, popped and checksum to drop to 0 immediately, and the state to return to IDLE. A new start then works normally.

Source files
------------

// File: rtl/lifo_pop_ctrl.sv
// lifo_pop_ctrl
// Read-side controller for an 8-bit, 16-deep LIFO. A start command pops either
// a programmed number of entries or drains the LIFO until empty. Every popped
// word is presented on a valid/ready stream, and the block keeps a running pop
// count and XOR checksum of the words it has popped.
//
// Ports:
//   clk          system clock, rising edge
//   resetn       asynchronous active-low reset
//   start        single-cycle request to begin a sequence (ignored while busy)
//   pop_count    entries to pop, 0 = drain until empty; latched on accepted start
//   lifo_re      pop strobe to the LIFO
//   lifo_dataout LIFO read data, valid the cycle after the pop strobe
//   lifo_empty   LIFO empty flag
//   m_data       popped word to the consumer
//   m_valid      m_data valid
//   m_ready      consumer accepts m_data
//   busy         sequence in progress (cycle after accepted start until DONE exits)
//   done         one-cycle pulse at sequence end
//   underrun     sequence hit empty before reaching pop_count; held until next start
//   popped       entries popped in the current/last sequence
//   checksum     XOR of all words popped in the current/last sequence
module lifo_pop_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [CNT_W-1:0]  pop_count,
    output logic              lifo_re,
    input  logic [DATA_W-1:0] lifo_dataout,
    input  logic              lifo_empty,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic              underrun,
    output logic [CNT_W-1:0]  popped,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_POP,
        S_CAP,
        S_OUT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_set_underrun;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_popped;
    logic [DATA_W-1:0]   r_checksum;
    logic [DATA_W-1:0]   r_data;
    logic                r_underrun;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_set_underrun = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                // A zero latched count means drain mode, so only a nonzero
                // count can terminate on reaching its target, and only a
                // nonzero count can come up short.
                if ((r_cnt != '0) && (r_popped == r_cnt)) begin
                    w_next = S_DONE;
                end else if (lifo_empty) begin
                    w_next         = S_DONE;
                    w_set_underrun = (r_cnt != '0);
                end else begin
                    w_next = S_POP;
                end
            end
            S_POP: begin
                w_next = S_CAP;
            end
            S_CAP: begin
                w_next = S_OUT;
            end
            S_OUT: begin
                if (m_ready) begin
                    w_next = S_CHECK;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt      <= '0;
            r_popped   <= '0;
            r_checksum <= '0;
            r_data     <= '0;
            r_underrun <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_cnt      <= pop_count;
                r_popped   <= '0;
                r_checksum <= '0;
                r_underrun <= 1'b0;
            end
            if ((r_state == S_CHECK) && w_set_underrun) begin
                r_underrun <= 1'b1;
            end
            // LIFO data becomes valid the cycle after the pop strobe, which is
            // exactly the CAP cycle.
            if (r_state == S_CAP) begin
                r_data     <= lifo_dataout;
                r_popped   <= r_popped + CNT_W'(1);
                r_checksum <= r_checksum ^ lifo_dataout;
            end
        end
    end

    assign lifo_re  = (r_state == S_POP);
    assign m_valid  = (r_state == S_OUT);
    assign done     = (r_state == S_DONE);
    assign busy     = (r_state != S_IDLE);
    assign m_data   = r_data;
    assign underrun = r_underrun;
    assign popped   = r_popped;
    assign checksum = r_checksum;

endmodule

// File: tb/tb_lifo_pop_ctrl.sv
// Testbench for lifo_pop_ctrl: a behavioural LIFO drives the DUT, a queue
// model predicts each sequence's words, count, checksum and underrun, and one
// compare process checks the DUT on every falling clock edge.
module tb_lifo_pop_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [4:0] pop_count;
    logic       lifo_re;
    logic [7:0] lifo_dataout = '0;
    logic       lifo_empty;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       busy;
    logic       done;
    logic       underrun;
    logic [4:0] popped;
    logic [7:0] checksum;

    always #5 clk = ~clk;

    lifo_pop_ctrl #(.DATA_W(8), .CNT_W(5)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .pop_count    (pop_count),
        .lifo_re      (lifo_re),
        .lifo_dataout (lifo_dataout),
        .lifo_empty   (lifo_empty),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .busy         (busy),
        .done         (done),
        .underrun     (underrun),
        .popped       (popped),
        .checksum     (checksum)
    );

    // Behavioural LIFO: data updates on an edge with re=1 and not empty.
    logic       push_en;
    logic [7:0] push_data;
    logic [7:0] mem [16];
    logic [4:0] sp = '0;

    assign lifo_empty = (sp == 5'd0);

    always @(posedge clk) begin
        if (push_en && (sp < 5'd16)) begin
            mem[sp[3:0]] <= push_data;
            sp           <= sp + 5'd1;
        end else if (lifo_re && (sp != 5'd0)) begin
            lifo_dataout <= mem[4'(sp - 5'd1)];
            sp           <= sp - 5'd1;
        end
    end

    // Reference model state, owned by the stimulus process.
    logic [7:0] model_stk [$];
    logic [7:0] exp_w [16];
    int         exp_n;
    logic [7:0] exp_cs;
    logic       exp_ur;
    logic       exp_empty;
    logic       pin_en;
    logic [7:0] pin_first;
    logic [7:0] pin_cs;
    int         pin_popped;
    logic       pin_ur;
    int         tmo_cnt = 0;

    // Compare-process state.
    int         n_pass = 0;
    int         n_total = 0;
    int         tmo_seen = 0;
    bit         in_seq = 0;
    int         since = 0;
    int         beat_i = 0;
    int         re_cnt = 0;
    bit         first_v = 0;
    bit         first_re = 0;
    bit         prev_vnr = 0;
    logic [7:0] prev_data = '0;
    logic [7:0] last_data = '0;
    int         hold_popped = 0;
    logic [7:0] hold_cs = '0;
    logic       hold_ur = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (tmo_cnt != tmo_seen) begin
            n_total++;
            $display("FAIL timeout: %0d bounded waits expired, expected 0", tmo_cnt - tmo_seen);
            tmo_seen = tmo_cnt;
        end
        if (!resetn) begin
            chk("rst_lifo_re",  32'(lifo_re),  32'd0);
            chk("rst_m_valid",  32'(m_valid),  32'd0);
            chk("rst_busy",     32'(busy),     32'd0);
            chk("rst_done",     32'(done),     32'd0);
            chk("rst_underrun", 32'(underrun), 32'd0);
            chk("rst_m_data",   32'(m_data),   32'd0);
            chk("rst_popped",   32'(popped),   32'd0);
            chk("rst_checksum", 32'(checksum), 32'd0);
            in_seq = 0; prev_vnr = 0; last_data = '0;
            hold_popped = 0; hold_cs = '0; hold_ur = 1'b0;
        end else if (!in_seq) begin
            chk("idle_busy",     32'(busy),     32'd0);
            chk("idle_m_valid",  32'(m_valid),  32'd0);
            chk("idle_lifo_re",  32'(lifo_re),  32'd0);
            chk("idle_done",     32'(done),     32'd0);
            chk("hold_popped",   32'(popped),   32'(hold_popped));
            chk("hold_checksum", 32'(checksum), 32'(hold_cs));
            chk("hold_underrun", 32'(underrun), 32'(hold_ur));
            chk("hold_m_data",   32'(m_data),   32'(last_data));
            if (start) begin
                in_seq = 1; since = 0; beat_i = 0; re_cnt = 0;
                first_v = 0; first_re = 0; prev_vnr = 0;
            end
        end else begin
            since++;
            chk("busy_in_seq", 32'(busy), 32'd1);
            if (since == 1) begin
                chk("clr_popped",   32'(popped),   32'd0);
                chk("clr_checksum", 32'(checksum), 32'd0);
                chk("clr_underrun", 32'(underrun), 32'd0);
            end
            if (lifo_re) begin
                re_cnt++;
                chk("re_while_empty", 32'(lifo_empty), 32'd0);
                chk("re_while_valid", 32'(m_valid),    32'd0);
                if (!first_re) begin
                    chk("re_latency", 32'(since), 32'd2);
                    first_re = 1;
                end
            end
            if (prev_vnr) begin
                chk("bp_valid_held", 32'(m_valid), 32'd1);
                chk("bp_data_held",  32'(m_data),  32'(prev_data));
            end
            if (m_valid && !first_v) begin
                chk("valid_latency", 32'(since), 32'd4);
                first_v = 1;
            end
            if (m_valid && m_ready) begin
                if (beat_i < exp_n) chk("beat_data", 32'(m_data), 32'(exp_w[beat_i]));
                else chk("beat_count", 32'(beat_i + 1), 32'(exp_n));
                if (pin_en && (beat_i == 0)) chk("pin_first", 32'(m_data), 32'(pin_first));
                last_data = m_data;
                beat_i++;
            end
            prev_vnr  = m_valid && !m_ready;
            prev_data = m_data;
            if (done) begin
                chk("done_popped",   32'(popped),     32'(exp_n));
                chk("done_checksum", 32'(checksum),   32'(exp_cs));
                chk("done_underrun", 32'(underrun),   32'(exp_ur));
                chk("done_beats",    32'(beat_i),     32'(exp_n));
                chk("done_re_count", 32'(re_cnt),     32'(exp_n));
                chk("done_empty",    32'(lifo_empty), 32'(exp_empty));
                if (exp_n == 0) chk("empty_done_latency", 32'(since <= 2), 32'd1);
                if (pin_en) begin
                    chk("pin_popped",   32'(popped),   32'(pin_popped));
                    chk("pin_checksum", 32'(checksum), 32'(pin_cs));
                    chk("pin_underrun", 32'(underrun), 32'(pin_ur));
                end
                hold_popped = exp_n; hold_cs = exp_cs; hold_ur = exp_ur;
                in_seq = 0; prev_vnr = 0;
            end
        end
    end

    task automatic push(input logic [7:0] d);
        if (model_stk.size() < 16) begin
            push_en = 1'b1; push_data = d;
            @(posedge clk); #1;
            push_en = 1'b0;
            model_stk.push_back(d);
        end
    endtask

    // rmode: 0 = always ready, 1 = random ready, 2 = first beat held off 5 cycles.
    // bmode: 1 = extra start pulses while busy, which must have no effect.
    task automatic run_seq(input int cnt, input int rmode, input int bmode);
        int sz;
        int held;
        sz = model_stk.size();
        exp_n = (cnt == 0) ? sz : ((cnt < sz) ? cnt : sz);
        exp_cs = '0;
        for (int i = 0; i < exp_n; i++) begin
            exp_w[i] = model_stk.pop_back();
            exp_cs   = exp_cs ^ exp_w[i];
        end
        exp_ur    = (cnt != 0) && (sz < cnt);
        exp_empty = (model_stk.size() == 0);
        held = 0;
        start = 1'b1; pop_count = cnt[4:0];
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            start = (bmode != 0) && ((c == 2) || (c == 4));
            if (start) pop_count = 5'd5;
            case (rmode)
                0: m_ready = 1'b1;
                1: m_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (m_valid && (held < 5)) begin
                        m_ready = 1'b0; held++;
                    end else if (held == 0) m_ready = 1'b0;
                    else m_ready = 1'b1;
                end
            endcase
            @(posedge clk); #1;
            if (done) break;
        end
        start = 1'b0;
        m_ready = 1'b1;
        if (!done) tmo_cnt++;
        @(posedge clk); #1;
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; pop_count = '0; m_ready = 1'b1;
        push_en = 1'b0; push_data = '0; pin_en = 1'b0;
        pin_first = '0; pin_cs = '0; pin_popped = 0; pin_ur = 1'b0;
        exp_n = 0; exp_cs = '0; exp_ur = 1'b0; exp_empty = 1'b1;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        // Empty LIFO, drain mode.
        run_seq(0, 0, 0);

        // Count of 2 out of three pushed.
        push(8'h11); push(8'h22); push(8'h33);
        pin_en = 1'b1; pin_first = 8'h33; pin_popped = 2; pin_cs = 8'h11; pin_ur = 1'b0;
        run_seq(2, 0, 0);
        pin_en = 1'b0;
        run_seq(0, 0, 0);

        // Underrun: count 4 with only two entries.
        push(8'hA5); push(8'h5A);
        pin_en = 1'b1; pin_first = 8'h5A; pin_popped = 2; pin_cs = 8'hFF; pin_ur = 1'b1;
        run_seq(4, 0, 0);
        pin_en = 1'b0;

        // Full drain of 16 random bytes with random backpressure.
        for (int i = 0; i < 16; i++) push(8'($urandom));
        run_seq(0, 1, 0);

        // Held-off first beat.
        for (int i = 0; i < 4; i++) push(8'($urandom));
        run_seq(3, 2, 0);

        // Start pulses while busy.
        push(8'($urandom)); push(8'($urandom));
        run_seq(1, 0, 1);

        // Random sequences.
        for (int k = 0; k < 8; k++) begin
            int np;
            np = $urandom_range(0, 16 - model_stk.size());
            for (int i = 0; i < np; i++) push(8'($urandom));
            run_seq($urandom_range(0, 20), 1, 0);
        end
        run_seq(0, 1, 0);

        // Reset while a word is held in OUT; the popped word is lost.
        push(8'h01); push(8'h02); push(8'h03);
        exp_n = 0; exp_cs = '0; exp_ur = 1'b0; exp_empty = 1'b0;
        m_ready = 1'b0;
        start = 1'b1; pop_count = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (m_valid) break;
            @(posedge clk); #1;
        end
        if (!m_valid) tmo_cnt++;
        #2 resetn = 1'b0;
        void'(model_stk.pop_back());
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b1; m_ready = 1'b1;
        @(posedge clk); #1;
        pin_en = 1'b1; pin_first = 8'h02; pin_popped = 2; pin_cs = 8'h03; pin_ur = 1'b0;
        run_seq(0, 0, 0);
        pin_en = 1'b0;

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
